mac_relu_unit: RTL and testbench
================================

# mac_relu_unit

Pipelined signed multiply-accumulate datapath with a combinational ReLU on the accumulator output. It is the compute element of the CNN convolution engine. The engine's sequencer clears it, streams one operand pair per cycle (nine for a 3×3 kernel), waits for the pipeline to drain, then writes the rectified result to the output RAM.

## Interface
Parameters:
- DATA_W, 32: width of operands, accumulator and outputs (two's complement).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset; clock clk.
- clr  in  1  synchronous accumulator clear (start of a new window).
- en  in  1  operand pair valid this cycle.
- a  in  DATA_W  signed operand (pixel).
- b  in  DATA_W  signed operand (kernel weight).
- acc  out  DATA_W  signed accumulator, registered.
- relu_out  out  DATA_W  max(acc, 0), combinational from acc.
- busy  out  1  a product is in flight (stage-1 valid).

## Operation
- Stage 1 (multiply):
  - On a clock edge with en=1, compute p = a*b as a full 2·DATA_W signed product.
  - Register p in prod_q and set prod_v=1.
  - With en=0, prod_v←0.
- Stage 2 (accumulate): on a clock edge with prod_v=1, acc ← acc + prod_q.
  - Default (wrap) arithmetic: keep the low DATA_W bits of prod_q and add modulo 2^DATA_W.
  - prod_v=0: acc holds its value.
- clr=1:
  - acc←0 and prod_v←0, discarding any in-flight product.
  - a/b presented in the same cycle are dropped. clr has priority over en.
- rst=1: same effect as clr, plus prod_q←0. rst has priority over everything.
- relu_out:
  - acc[DATA_W-1]=1 gives 0.
  - Otherwise relu_out = acc, reinterpreted as an unsigned value.
- busy = prod_v.
- No backpressure: every en=1 cycle that is not cleared is accepted.

## Timing
- Reset values: acc=0, relu_out=0, busy=0, prod_q=0, prod_v=0.
- Latency:
  - Pair sampled at edge N is reflected in acc after edge N+1.
  - relu_out updates in the same cycle as acc.
- Throughput: one pair per cycle, back-to-back, with no bubbles required.
- Drain: after the last en=1 at edge N, acc is final after edge N+1 (busy=0 from edge N+1, assuming en=0 there). The sequencer may wait longer; acc is stable until the next en or clr.
- clr at edge N followed by en=1 at N+1: first product is added at N+2 onto a clean 0.
- en with gaps: idle cycles neither add nor clear.
- rst mid-window: window is lost, all state as reset.

## Configuration
- MAC_RELU_SAT_EN defined:
  - Stage-1 product is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1] before registering.
  - Stage-2 sum saturates to the same range instead of wrapping.
- Undefined: pure modulo-2^DATA_W wrap arithmetic as above.
- ReLU behaviour is identical in both builds.

## Test plan
- Reset: assert rst for 2 cycles while en=1, a=5, b=5 → acc=0, relu_out=0, busy=0 throughout and one cycle after release.
- Edge kernel:
  - Stimulus: clr, then 9 consecutive pairs a=1..9, b=−1,−1,−1,0,0,0,1,1,1.
  - Response: acc=18, relu_out=18 exactly one cycle after the last en. Held while en=0.
- Negative result: same stimulus with b negated → acc=−18 (0xFFFFFFEE), relu_out=0.
- clr priority and gaps:
  - Accumulate 3×4=12. Then assert clr and en together with a=7, b=7 → acc=0.
  - Then feed a=2, b=3, idle 2 cycles, feed a=1, b=1 → acc=7.
- Overflow, pair 0x7FFFFFFF×1 twice:
  - Wrap build: acc=0xFFFFFFFE, relu_out=0.
  - MAC_RELU_SAT_EN build: acc=0x7FFFFFFF, relu_out=0x7FFFFFFF.
- Wide product, a=0x10000, b=0x10000:
  - Wrap build: acc=0.
  - SAT build: acc=0x7FFFFFFF.

Source files
------------

// File: rtl/mac_relu_unit.sv
// mac_relu_unit: two-stage signed multiply-accumulate with a ReLU on the
// accumulator. It is the compute element of the convolution engine.
//   Stage 1 registers a*b, and stage 2 adds the registered product into acc.
//   relu_out is max(acc, 0), derived combinationally from the acc register.
// Build option: define MAC_RELU_SAT_EN to clamp the stage-1 product and to
// saturate the stage-2 sum to the signed DATA_W range. The default build
// wraps modulo 2^DATA_W.
module mac_relu_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] relu_out,
    output logic              busy
);

    // prod_q holds only the DATA_W bits that stage 2 consumes. In the wrap
    // build these are the low bits of the full product. In the saturating
    // build they are the product after clamping.
    logic [DATA_W-1:0] prod_q, prod_d;
    logic              prod_v_q;
    logic [DATA_W-1:0] acc_q, acc_d;

    // NOTE: every always_comb output is assigned on every path (defaults first)
    // so that no latch is inferred.
`ifdef MAC_RELU_SAT_EN
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [2*DATA_W-1:0] prod_full;
    logic [DATA_W:0]     prod_hi;
    logic [DATA_W:0]     sum_x;

    // Full signed product clamped to DATA_W, then a saturating accumulate
    always_comb begin
        prod_full = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        prod_hi   = prod_full[2*DATA_W-1:DATA_W-1];
        prod_d    = prod_full[DATA_W-1:0];
        // The product fits only when its top DATA_W+1 bits are all sign copies.
        if (!(&prod_hi) && (|prod_hi)) begin
            prod_d = prod_full[2*DATA_W-1] ? SMIN : SMAX;
        end

        sum_x = {acc_q[DATA_W-1], acc_q} + {prod_q[DATA_W-1], prod_q};
        acc_d = sum_x[DATA_W-1:0];
        // Overflow shows up as a disagreement between the guard bit and the
        // sign bit. The guard bit carries the true sign.
        if (sum_x[DATA_W] != sum_x[DATA_W-1]) begin
            acc_d = sum_x[DATA_W] ? SMIN : SMAX;
        end
    end
`else
    // Wrap arithmetic: the low DATA_W bits of a*b are the same whether the
    // operands are read as signed or unsigned
    always_comb begin
        prod_d = a * b;
        acc_d  = acc_q + prod_q;
    end
`endif

    // Pipeline registers. Priority is rst, then clr, then normal operation.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else if (clr) begin
            // Start of a new window. Any in-flight product and any operands
            // presented in this cycle are dropped.
            prod_v_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            prod_v_q <= en;
            if (en) begin
                prod_q <= prod_d;
            end
            if (prod_v_q) begin
                acc_q <= acc_d;
            end
        end
    end

    assign acc      = acc_q;
    assign relu_out = acc_q[DATA_W-1] ? '0 : acc_q;
    assign busy     = prod_v_q;

endmodule

// File: tb/tb_mac_relu_unit.sv
// Self-checking bench for mac_relu_unit (DATA_W = 32). The bench runs the
// directed scenarios first and then randomised traffic. A reference model
// works in plain integer arithmetic and checks acc, relu_out and busy after
// every clock edge.
module tb_mac_relu_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] acc;
    logic [W-1:0] relu_out;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    mac_relu_unit #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (en),
        .a        (a),
        .b        (b),
        .acc      (acc),
        .relu_out (relu_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state: the accumulator value, plus the product that
    // the most recent accepted pair will add at the next edge.
    int     m_acc    = 0;
    bit     m_pend_v = 1'b0;
    longint m_pend   = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic longint clamp(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint mdl_mul(input int x, input int y);
        longint p;
        p = longint'(x) * longint'(y);
`ifdef MAC_RELU_SAT_EN
        p = clamp(p);
`endif
        return p;
    endfunction

    function automatic int mdl_add(input int s, input longint p);
`ifdef MAC_RELU_SAT_EN
        return int'(clamp(longint'(s) + p));
`else
        return s + int'(p);
`endif
    endfunction

    // Apply the effect of one clock edge to the model, using the inputs the
    // bench is currently driving.
    task automatic model_edge();
        if (rst || clr) begin
            m_acc    = 0;
            m_pend_v = 1'b0;
        end else begin
            if (m_pend_v) m_acc = mdl_add(m_acc, m_pend);
            m_pend_v = en;
            if (en) m_pend = mdl_mul(int'(a), int'(b));
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge, then a comparison of all outputs against the model.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("acc", acc, m_acc);
        check("relu", relu_out, (m_acc < 0) ? 32'd0 : m_acc);
        check("busy", {31'd0, busy}, {31'd0, m_pend_v});
    endtask

    task automatic pair(input int x, input int y);
        en = 1'b1; a = x; b = y;
        step();
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    int kb[9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

    initial begin
        // Reset held for 2 cycles while the operand inputs are active
        rst = 1'b1; en = 1'b1; a = 5; b = 5;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_acc", acc, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0; en = 1'b0;
        step();
        check("rst_after_acc", acc, 32'd0);
        check("rst_after_relu", relu_out, 32'd0);
        check("rst_after_busy", {31'd0, busy}, 32'd0);

        // Edge-detect kernel
        clear();
        for (int i = 0; i < 9; i++) pair(i + 1, kb[i]);
        step();
        check("edge_acc", acc, 32'd18);
        check("edge_relu", relu_out, 32'd18);
        idle(3);
        check("edge_hold", acc, 32'd18);

        // The same window with negated weights
        clear();
        for (int i = 0; i < 9; i++) pair(i + 1, -kb[i]);
        step();
        check("neg_acc", acc, 32'hFFFF_FFEE);
        check("neg_relu", relu_out, 32'd0);

        // clr has priority over en. Idle gaps neither add nor clear.
        clear();
        pair(3, 4);
        step();
        check("pre_clr_acc", acc, 32'd12);
        clr = 1'b1; en = 1'b1; a = 7; b = 7;
        step();
        clr = 1'b0; en = 1'b0;
        check("clr_en_acc", acc, 32'd0);
        check("clr_en_busy", {31'd0, busy}, 32'd0);
        pair(2, 3);
        idle(2);
        pair(1, 1);
        step();
        check("gap_acc", acc, 32'd7);

        // Overflow: 0x7FFFFFFF * 1, accumulated twice
        clear();
        pair(32'h7FFF_FFFF, 1);
        pair(32'h7FFF_FFFF, 1);
        step();
`ifdef MAC_RELU_SAT_EN
        check("ovf_acc", acc, 32'h7FFF_FFFF);
        check("ovf_relu", relu_out, 32'h7FFF_FFFF);
`else
        check("ovf_acc", acc, 32'hFFFF_FFFE);
        check("ovf_relu", relu_out, 32'd0);
`endif

        // Wide product: 0x10000 * 0x10000
        clear();
        pair(32'h1_0000, 32'h1_0000);
        step();
`ifdef MAC_RELU_SAT_EN
        check("wide_acc", acc, 32'h7FFF_FFFF);
`else
        check("wide_acc", acc, 32'd0);
`endif

        // Reset in the middle of a window
        clear();
        pair(9, 9);
        en = 1'b1; a = 4; b = 4; rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        step();
        check("rst_mid_acc", acc, 32'd0);

        // Randomised traffic with occasional clr and rst
        for (int i = 0; i < 400; i++) begin
            int r;
            r   = int'($urandom_range(0, 99));
            clr = (r < 5);
            rst = (r == 99);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = int'($urandom_range(0, 200)) - 100;
                b = int'($urandom_range(0, 200)) - 100;
            end
            step();
        end
        clr = 1'b0; rst = 1'b0; en = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
